// File: rtl/host_disp_pkg.sv
// host_disp_pkg
// Shared types and constants for the word-guessing display controller:
// the FSM state enum, LCD character codes and the fixed 16-column banners.
// Optional feature macro: HOST_DISP_FLASH_EN (adds the FLASH state).
package host_disp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
`ifdef HOST_DISP_FLASH_EN
    FLASH = 3'd2,
`endif
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_UNDER = 8'h5F;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_Z     = 8'h5A;

  // Banners are left-justified text padded with spaces to 16 columns.
  localparam logic [127:0] BNR_BLANK = {16{CH_SPACE}};
  localparam logic [127:0] BNR_LOAD  = {"LOAD WORD", {7{CH_SPACE}}};
  localparam logic [127:0] BNR_WRONG = {"WRONG!", {10{CH_SPACE}}};
  localparam logic [127:0] BNR_WIN   = {"YOU WIN", {9{CH_SPACE}}};
  localparam logic [127:0] BNR_OVER  = {"GAME OVER", {7{CH_SPACE}}};
  localparam logic [127:0] BNR_MISS  = {"X:", {14{CH_SPACE}}};

  function automatic logic is_upper(input logic [7:0] ch);
    return (ch >= CH_A) && (ch <= CH_Z);
  endfunction

endpackage

// File: rtl/host_disp_if.sv
// host_disp_if
// Host-side bus of the display controller.
//   master: drives word/word_load/letter/guess_valid, reads display + status
//   slave : the controller side
interface host_disp_if #(
  parameter int WORD_LEN     = 5,
  parameter int MAX_MISTAKES = 6
);
  logic [8*WORD_LEN-1:0]                 word;
  logic                                  word_load;
  logic [7:0]                            letter;
  logic                                  guess_valid;
  logic [127:0]                          top;
  logic [127:0]                          bottom;
  logic [WORD_LEN-1:0]                   reveal_mask;
  logic [$clog2(MAX_MISTAKES+1)-1:0]     num_mistakes;
  logic                                  game_won;
  logic                                  game_lost;
  logic                                  busy;

  modport master (
    output word, word_load, letter, guess_valid,
    input  top, bottom, reveal_mask, num_mistakes, game_won, game_lost, busy
  );

  modport slave (
    input  word, word_load, letter, guess_valid,
    output top, bottom, reveal_mask, num_mistakes, game_won, game_lost, busy
  );
endinterface

// File: rtl/host_disp_match.sv
// host_disp_match
// Compares one guess letter against every character of the stored word.
//   i_letter : guess character
//   i_word   : word, character i in bits [8*i +: 8] (i = WORD_LEN-1 is leftmost)
//   o_hit    : bit i set when character i equals i_letter
module host_disp_match
  import host_disp_pkg::*;
#(
  parameter int WORD_LEN = 5
) (
  input  logic [7:0]            i_letter,
  input  logic [8*WORD_LEN-1:0] i_word,
  output logic [WORD_LEN-1:0]   o_hit
);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      o_hit[i] = (i_word[8*i +: 8] == i_letter);
    end
  end

endmodule

// File: rtl/host_disp_multi.sv
// host_disp_multi
// Word-guessing game controller driving a 2x16 character LCD.
//   clk : clock, rst : synchronous active-high reset
//   bus : host_disp_if.slave (word load, guesses, LCD lines, status flags)
// Optional feature macro: HOST_DISP_FLASH_EN adds a timed "WRONG!" banner
// after each new miss; without it busy is constant 0.
//
// state | meaning
// IDLE  | no word loaded, shows "LOAD WORD"
// PLAY  | accepting guesses
// FLASH | miss banner shown for FLASH_CYCLES, guesses dropped
// WON   | all characters revealed
// LOST  | MAX_MISTAKES distinct misses
module host_disp_multi
  import host_disp_pkg::*;
#(
  parameter int WORD_LEN     = 5,
  parameter int MAX_MISTAKES = 6,
  parameter int FLASH_CYCLES = 20
) (
  input logic        clk,
  input logic        rst,
  host_disp_if.slave bus
);

  localparam int NMW = $clog2(MAX_MISTAKES + 1);

  state_t                r_state;
  logic [8*WORD_LEN-1:0] r_word;
  logic [WORD_LEN-1:0]   r_mask;
  logic [NMW-1:0]        r_nmiss;
  logic [7:0]            r_miss [MAX_MISTAKES];

  logic [WORD_LEN-1:0]   w_hit;
  logic [WORD_LEN-1:0]   w_mask_nx;
  logic                  w_guess;
  logic                  w_seen;
  logic                  w_miss_new;
  logic [127:0]          w_line_play;
  logic [127:0]          w_line_full;
  logic [127:0]          w_line_miss;
  logic [127:0]          w_top;
  logic [127:0]          w_bot;

`ifdef HOST_DISP_FLASH_EN
  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
`else
  logic w_unused_flash;
  assign w_unused_flash = (FLASH_CYCLES > 0);
`endif

  host_disp_match #(.WORD_LEN(WORD_LEN)) u_match (
    .i_letter (bus.letter),
    .i_word   (r_word),
    .o_hit    (w_hit)
  );

  assign w_mask_nx = r_mask | w_hit;
  // word_load wins over a same-cycle guess.
  assign w_guess   = bus.guess_valid && !bus.word_load && (r_state == PLAY)
                     && is_upper(bus.letter);

  always_comb begin
    w_seen = 1'b0;
    for (int j = 0; j < MAX_MISTAKES; j++) begin
      if ((NMW'(j) < r_nmiss) && (r_miss[j] == bus.letter)) w_seen = 1'b1;
    end
  end

  assign w_miss_new = w_guess && !(|w_hit) && !w_seen;

  // Miss letters need no reset: only entries below r_nmiss are ever read.
  always_ff @(posedge clk) begin
    if (w_miss_new) begin
      for (int j = 0; j < MAX_MISTAKES; j++) begin
        if (NMW'(j) == r_nmiss) r_miss[j] <= bus.letter;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_mask  <= '0;
      r_nmiss <= '0;
`ifdef HOST_DISP_FLASH_EN
      r_cnt   <= '0;
`endif
    end else if (bus.word_load) begin
      r_state <= PLAY;
      r_word  <= bus.word;
      r_mask  <= '0;
      r_nmiss <= '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_guess && (|w_hit)) begin
            r_mask <= w_mask_nx;
            if (&w_mask_nx) r_state <= WON;
          end else if (w_miss_new) begin
            r_nmiss <= r_nmiss + 1'b1;
            if (r_nmiss == NMW'(MAX_MISTAKES - 1)) begin
              r_state <= LOST;
            end else begin
`ifdef HOST_DISP_FLASH_EN
              r_state <= FLASH;
              r_cnt   <= CW'(FLASH_CYCLES - 1);
`else
              r_state <= PLAY;
`endif
            end
          end
        end
`ifdef HOST_DISP_FLASH_EN
        FLASH: begin
          if (r_cnt == '0) r_state <= PLAY;
          else             r_cnt   <= r_cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Display lines, all decoded from registers only.
  always_comb begin
    w_line_play = BNR_BLANK;
    w_line_full = BNR_BLANK;
    for (int c = 0; c < WORD_LEN; c++) begin
      w_line_full[127-8*c -: 8] = r_word[8*(WORD_LEN-1-c) +: 8];
      w_line_play[127-8*c -: 8] = r_mask[WORD_LEN-1-c] ?
                                  r_word[8*(WORD_LEN-1-c) +: 8] : CH_UNDER;
    end
    w_line_miss = BNR_MISS;
    for (int j = 0; j < MAX_MISTAKES; j++) begin
      if (NMW'(j) < r_nmiss) w_line_miss[111-8*j -: 8] = r_miss[j];
    end
  end

  always_comb begin
    w_top = BNR_BLANK;
    w_bot = BNR_LOAD;
    case (r_state)
      PLAY:  begin w_top = w_line_play; w_bot = w_line_miss; end
`ifdef HOST_DISP_FLASH_EN
      FLASH: begin w_top = w_line_play; w_bot = BNR_WRONG;   end
`endif
      WON:   begin w_top = w_line_full; w_bot = BNR_WIN;     end
      LOST:  begin w_top = w_line_full; w_bot = BNR_OVER;    end
      default: ;
    endcase
  end

  assign bus.top          = w_top;
  assign bus.bottom       = w_bot;
  assign bus.reveal_mask  = r_mask;
  assign bus.num_mistakes = r_nmiss;
  assign bus.game_won     = (r_state == WON);
  assign bus.game_lost    = (r_state == LOST);
`ifdef HOST_DISP_FLASH_EN
  assign bus.busy         = (r_state == FLASH);
`else
  assign bus.busy         = 1'b0;
`endif

endmodule

// File: tb/tb_host_disp_multi.sv
// tb_host_disp_multi
// Scoreboard bench: every driven cycle pushes the reference model's expected
// display/status into a queue; a monitor pops and compares after each edge.
module tb_host_disp_multi;

  localparam int WL = 5;
  localparam int MM = 6;
  localparam int FC = 20;
  localparam int WW = 8 * WL;
`ifdef HOST_DISP_FLASH_EN
  localparam int FLASH_LEN = FC;
`else
  localparam int FLASH_LEN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  host_disp_if #(.WORD_LEN(WL), .MAX_MISTAKES(MM)) bus();

  host_disp_multi #(.WORD_LEN(WL), .MAX_MISTAKES(MM), .FLASH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [127:0]  top;
    logic [127:0]  bot;
    logic [WL-1:0] mask;
    logic [2:0]    nm;
    logic          won;
    logic          lost;
    logic          busy;
  } snap_t;

  snap_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: game described as word, revealed columns, miss list.
  bit         m_loaded, m_won, m_lost;
  int         m_flash;
  logic [7:0] m_w [WL];
  bit         m_rev [WL];
  logic [7:0] m_miss [$];

  function automatic logic [127:0] text16(input string t);
    logic [127:0] b;
    b = {16{8'h20}};
    for (int i = 0; i < t.len(); i++) b[127-8*i -: 8] = t[i];
    return b;
  endfunction

  function automatic void model_step(input bit r, input bit ld, input logic [WW-1:0] wv,
                                     input bit gv, input logic [7:0] l);
    bit any, all, seen;
    if (r) begin
      m_loaded = 0; m_won = 0; m_lost = 0; m_flash = 0;
      m_miss.delete();
      for (int c = 0; c < WL; c++) m_rev[c] = 0;
    end else if (ld) begin
      m_loaded = 1; m_won = 0; m_lost = 0; m_flash = 0;
      m_miss.delete();
      for (int c = 0; c < WL; c++) begin
        m_w[c]   = wv[WW-1-8*c -: 8];
        m_rev[c] = 0;
      end
    end else if (m_flash > 0) begin
      m_flash--;
    end else if (m_loaded && !m_won && !m_lost && gv && l >= 8'h41 && l <= 8'h5A) begin
      any = 0; all = 1; seen = 0;
      for (int c = 0; c < WL; c++) if (m_w[c] == l) begin m_rev[c] = 1; any = 1; end
      if (any) begin
        for (int c = 0; c < WL; c++) if (!m_rev[c]) all = 0;
        m_won = all;
      end else begin
        foreach (m_miss[j]) if (m_miss[j] == l) seen = 1;
        if (!seen) begin
          m_miss.push_back(l);
          if (m_miss.size() == MM) m_lost = 1;
          else m_flash = FLASH_LEN;
        end
      end
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.top = {16{8'h20}};
    if (m_loaded)
      for (int c = 0; c < WL; c++)
        s.top[127-8*c -: 8] = (m_won || m_lost || m_rev[c]) ? m_w[c] : 8'h5F;
    if (!m_loaded)       s.bot = text16("LOAD WORD");
    else if (m_won)      s.bot = text16("YOU WIN");
    else if (m_lost)     s.bot = text16("GAME OVER");
    else if (m_flash > 0) s.bot = text16("WRONG!");
    else begin
      s.bot = text16("X:");
      foreach (m_miss[j]) s.bot[127-8*(2+j) -: 8] = m_miss[j];
    end
    for (int c = 0; c < WL; c++) s.mask[WL-1-c] = m_rev[c];
    s.nm   = 3'(m_miss.size());
    s.won  = m_won;
    s.lost = m_lost;
    s.busy = (m_flash > 0);
    return s;
  endfunction

  function automatic void chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    end
  endfunction

  // Monitor: outputs are registered, sampled 2 time units after each edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("top",          bus.top,          e.top);
        chk("bottom",       bus.bottom,       e.bot);
        chk("reveal_mask",  bus.reveal_mask,  e.mask);
        chk("num_mistakes", bus.num_mistakes, e.nm);
        chk("game_won",     bus.game_won,     e.won);
        chk("game_lost",    bus.game_lost,    e.lost);
        chk("busy",         bus.busy,         e.busy);
      end
    end
  end

  function automatic logic [WW-1:0] rnd_word();
    return WW'({$urandom(), $urandom()});
  endfunction

  task automatic step(input bit r, input bit ld, input logic [WW-1:0] wv,
                      input bit gv, input logic [7:0] l);
    @(negedge clk);
    rst             = r;
    bus.word_load   = ld;
    bus.word        = wv;
    bus.guess_valid = gv;
    bus.letter      = l;
    model_step(r, ld, wv, gv, l);
    sb.push_back(model_snap());
  endtask

  task automatic guess(input logic [7:0] l);
    step(0, 0, rnd_word(), 1, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, rnd_word(), 0, 8'($urandom()));
  endtask

  task automatic load(input logic [WW-1:0] w);
    step(0, 1, w, 0, 8'h00);
  endtask

  localparam logic [WW-1:0] MOORE = 40'h4D4F4F5245;
  localparam logic [WW-1:0] ZEBRA = 40'h5A45425241;
  localparam logic [7:0] MISS_SET [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h46, 8'h47};

  initial begin
    logic [WW-1:0] w;
    logic [7:0]    l;
    int            r;
    rst = 1'b1; bus.word_load = 1'b0; bus.word = '0; bus.guess_valid = 1'b0; bus.letter = '0;

    step(1, 0, '0, 0, 8'h00);
    step(1, 1, MOORE, 1, 8'h4D);     // rst overrides load and guess
    guess(8'h41);                    // IDLE ignores guesses
    idle(1);

    // Main game: hits, illegal letters, miss + banner, repeat miss, win.
    load(MOORE);
    guess(8'h4F);                    // O -> 01100
    guess(8'h6F);                    // lowercase ignored
    guess(8'h40);                    // just below 'A'
    guess(8'h5B);                    // just above 'Z'
    guess(8'h50);                    // P miss
    guess(8'h50);                    // repeat during banner
    idle(FLASH_LEN);
    guess(8'h50);                    // repeat in PLAY
    guess(8'h4D); guess(8'h4F); guess(8'h52); guess(8'h45);
    guess(8'h5A);                    // after win: no effect
    idle(2);

    // Six distinct misses end the game without a banner on the last one.
    load(MOORE);
    for (int i = 0; i < 6; i++) begin
      guess(MISS_SET[i]);
      idle(FLASH_LEN + 1);
    end
    guess(8'h4D);                    // LOST ignores guesses
    idle(2);

    // Reset in the middle of the banner.
    load(MOORE);
    guess(8'h51);
    idle(5);
    step(1, 0, '0, 1, 8'h4D);
    idle(2);

    // Load with a simultaneous guess: guess dropped.
    step(0, 1, MOORE, 1, 8'h4D);
    idle(1);

    // Letter bounds 'A' and 'Z' as hits.
    load(ZEBRA);
    guess(8'h5A); guess(8'h41); guess(8'h42); guess(8'h45); guess(8'h52);
    idle(1);

    // Random games over a small alphabet so hits and misses both occur.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        step(1, 0, rnd_word(), $urandom_range(0, 1), 8'h41);
      end else if (r < 8) begin
        for (int c = 0; c < WL; c++) w[8*c +: 8] = 8'h41 + 8'($urandom_range(0, 7));
        step(0, 1, w, $urandom_range(0, 1), 8'h41 + 8'($urandom_range(0, 7)));
      end else begin
        r = $urandom_range(0, 19);
        if (r < 16)       l = 8'h41 + 8'(r);
        else if (r == 16) l = 8'h40;
        else if (r == 17) l = 8'h5B;
        else if (r == 18) l = 8'h61 + 8'($urandom_range(0, 7));
        else              l = 8'h5A;
        step(0, 0, rnd_word(), $urandom_range(0, 1), l);
      end
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
